fft_result_tx: RTL and testbench
================================

Name: fft_result_tx

Overview:
- Downstream neighbour of the bit-reversed read sequencer in the FFT output path.
- Watches the sequencer's bank read enables and captures the complex sample returned one cycle later from bank0 or bank1.
- Serializes the sample MSB-first as bytes over a valid/ready byte stream for the UART/host link.
- Returns a one-cycle completion pulse that drives the sequencer's i_tx_valid, and counts samples to flag end of frame.

Parameters:
- N, 32, FFT length (samples per frame)
- R, 5, log2(N); sample counter width
- DW, 16, bits per real/imag component; must be a multiple of 4 so 2*DW is a whole number of bytes

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous active-high reset
- i_m0_r_en  input  1  bank0 read enable from the sequencer
- i_m1_r_en  input  1  bank1 read enable from the sequencer
- i_m0_rdata  input  2*DW  bank0 read data {re,im}, valid the cycle after i_m0_r_en
- i_m1_rdata  input  2*DW  bank1 read data {re,im}, valid the cycle after i_m1_r_en
- o_byte_data  output  8  current output byte
- o_byte_valid  output  1  byte valid
- i_byte_ready  input  1  sink ready; a transfer occurs on valid&&ready at a rising edge
- o_tx_valid  output  1  one-cycle pulse: sample fully sent (to sequencer i_tx_valid)
- o_frame_done  output  1  one-cycle pulse, coincident with the o_tx_valid of sample N-1
- o_busy  output  1  high in any state other than IDLE
- o_overrun  output  1  sticky: read enable seen while not IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; sample counter 0; byte index 0; shift register 0.
- Reset mid-operation: o_byte_valid drops at the next edge and any partial sample is discarded.
- NB = 2*DW/8 bytes per sample (default 4).
- State IDLE:
  - If i_m0_r_en or i_m1_r_en, latch bank select and go to CAPTURE.
  - If both enables are high, bank0 wins (illegal case; no flag).
- State CAPTURE (the cycle after the enable):
  - Load the shift register from the selected bank's rdata.
  - Set byte index to 0 and go to SEND.
- State SEND:
  - o_byte_valid=1; o_byte_data = shift register [2*DW-1 -: 8].
  - Byte order: re MSB first, then im, ending with im LSB byte.
  - On valid&&ready: shift left by 8 and increment the byte index.
  - On the transfer of byte NB-1, go to DONE.
  - o_byte_data and o_byte_valid hold stable while ready is low. No timeout.
- State DONE (one cycle):
  - o_tx_valid=1.
  - If the sample counter is N-1: o_frame_done=1 and the counter wraps to 0; otherwise the counter increments.
  - Next state is IDLE.
- End-to-end latency with ready held high: enable at cycle t, CAPTURE at t+1, bytes at t+2..t+1+NB, o_tx_valid at t+2+NB.
- Overrun: any read enable while the state is not IDLE sets o_overrun (cleared only by reset). That enable is ignored and the current sample is unaffected.
- A read enable in the same cycle as DONE also counts as overrun. IDLE is the only accepting state.
- All outputs are registered except o_byte_data, which is driven directly from the shift register.

Decomposition:
- Shared package fft_pkg holds:
  - DW and the NB derivation
  - state encoding localparams ST_IDLE, ST_CAPTURE, ST_SEND, ST_DONE
  - the complex sample packing convention {re[DW-1:0], im[DW-1:0]}
- One natural sub-module: fft_byte_shifter, a parallel-load, shift-by-8 register with byte index and last-byte flag, controlled by the top FSM.

Test Plan:
- Bank0 sample: pulse i_m0_r_en, next cycle i_m0_rdata=32'h1234_ABCD, ready=1 -> bytes 12,34,AB,CD on 4 consecutive cycles; o_tx_valid exactly 1 cycle later (enable+6); counter=1.
- Bank1 sample with backpressure: i_m1_rdata=32'hDEAD_BEEF, ready low for 3 cycles on byte 2 -> byte AD held stable with valid high; total of exactly 4 transfers (DE,AD,BE,EF); o_overrun stays 0.
- Full frame: 32 sequenced reads alternating banks -> 128 bytes in order; o_frame_done high only with the 32nd o_tx_valid; counter back to 0; the 33rd sample sends normally with no frame_done.
- Overrun: assert i_m0_r_en during SEND -> o_overrun=1 and sticky; byte stream of the current sample unchanged; no extra o_tx_valid.
- Reset mid-SEND after 2 bytes: i_rst for 1 cycle -> next cycle o_byte_valid=0, o_busy=0, counter=0, o_overrun=0; a new enable then sends a full 4-byte sample.
- Simultaneous enables: i_m0_r_en=i_m1_r_en=1 with rdata0=32'h0000_0001, rdata1=32'hFFFF_FFFF -> bytes 00,00,00,01 are sent.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result path: sample geometry, transmitter
// state encoding and the {re, im} complex sample packing.
package fft_pkg;

    localparam int unsigned N  = 32;
    localparam int unsigned R  = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 2 * DW;
    localparam int unsigned NB = SW / 8;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    // Real part occupies the upper half so it leaves the link first.
    function automatic logic [SW-1:0] pack_sample(input logic [DW-1:0] re,
                                                  input logic [DW-1:0] im);
        return {re, im};
    endfunction

endpackage

// File: rtl/fft_byte_shifter.sv
// Parallel-load shift register that presents one sample MSB byte first,
// with a byte index and a last-byte flag for the controlling FSM.
module fft_byte_shifter
    import fft_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [SW-1:0] i_load_data,
    input  logic          i_shift,
    output logic [7:0]    o_byte_c,
    output logic          o_last_c
);

    logic [SW-1:0] r_shreg;
    logic [IW-1:0] r_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_shreg <= i_load_data;
            r_idx   <= '0;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[SW-9:0], 8'h00};
            r_idx   <= r_idx + IW'(1);
        end
    end

    assign o_byte_c = r_shreg[SW-1 -: 8];
    assign o_last_c = (r_idx == IW'(NB - 1));

endmodule

// File: rtl/fft_result_tx.sv
// Captures one bank read-back sample per sequencer request, streams it out as
// bytes over valid/ready, and reports per-sample and per-frame completion.
module fft_result_tx
    import fft_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_m0_r_en,
    input  logic          i_m1_r_en,
    input  logic [SW-1:0] i_m0_rdata,
    input  logic [SW-1:0] i_m1_rdata,
    output logic [7:0]    o_byte_data,
    output logic          o_byte_valid,
    input  logic          i_byte_ready,
    output logic          o_tx_valid,
    output logic          o_frame_done,
    output logic          o_busy,
    output logic          o_overrun
);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_bank_sel;
    logic [R-1:0]    r_sample_cnt;
    logic            w_en_any;
    logic            w_load;
    logic            w_shift;
    logic            w_last;
    logic            w_cnt_last;
    cplx_t           w_sel_sample;

    assign w_en_any     = i_m0_r_en | i_m1_r_en;
    assign w_cnt_last   = (r_sample_cnt == R'(N - 1));
    assign w_sel_sample = r_bank_sel ? cplx_t'(i_m1_rdata) : cplx_t'(i_m0_rdata);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_en_any) begin
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_load       = 1'b1;
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                if (i_byte_ready) begin
                    w_shift = 1'b1;
                    if (w_last) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Bank0 takes priority when both enables arrive together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bank_sel <= 1'b0;
        end else if (r_state == ST_IDLE && w_en_any) begin
            r_bank_sel <= ~i_m0_r_en;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sample_cnt <= '0;
        end else if (r_state == ST_DONE) begin
            r_sample_cnt <= w_cnt_last ? '0 : r_sample_cnt + R'(1);
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_byte_valid <= 1'b0;
            o_tx_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_byte_valid <= (w_next_state == ST_SEND);
            o_tx_valid   <= (w_next_state == ST_DONE);
            o_frame_done <= (w_next_state == ST_DONE) && w_cnt_last;
            o_busy       <= (w_next_state != ST_IDLE);
            o_overrun    <= o_overrun | (w_en_any && (r_state != ST_IDLE));
        end
    end

    fft_byte_shifter u_shifter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_load_data (pack_sample(w_sel_sample.re, w_sel_sample.im)),
        .i_shift     (w_shift),
        .o_byte_c    (o_byte_data),
        .o_last_c    (w_last)
    );

endmodule

// File: tb/tb_fft_result_tx.sv
// Directed self-checking bench for fft_result_tx.
module tb_fft_result_tx;

    logic        clk;
    logic        i_rst;
    logic        i_m0_r_en;
    logic        i_m1_r_en;
    logic [31:0] i_m0_rdata;
    logic [31:0] i_m1_rdata;
    logic [7:0]  o_byte_data;
    logic        o_byte_valid;
    logic        i_byte_ready;
    logic        o_tx_valid;
    logic        o_frame_done;
    logic        o_busy;
    logic        o_overrun;

    int n_vec  = 0;
    int n_err  = 0;
    int n_xfer = 0;

    fft_result_tx dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_m0_r_en    (i_m0_r_en),
        .i_m1_r_en    (i_m1_r_en),
        .i_m0_rdata   (i_m0_rdata),
        .i_m1_rdata   (i_m1_rdata),
        .o_byte_data  (o_byte_data),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_tx_valid   (o_tx_valid),
        .o_frame_done (o_frame_done),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_byte_valid && i_byte_ready) n_xfer++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp);
        chk(tag, 32'(dut.r_sample_cnt), exp);
    endtask

    // One sample with ready held high: enable, capture, NB bytes, DONE.
    task automatic run_sample(input string tag, input logic e0, input logic e1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] exp, input logic exp_fd);
        logic [31:0] e;
        e = exp;
        i_m0_r_en = e0;
        i_m1_r_en = e1;
        tick();
        i_m0_r_en  = 1'b0;
        i_m1_r_en  = 1'b0;
        i_m0_rdata = d0;
        i_m1_rdata = d1;
        chk({tag, ".cap_busy"}, 32'(o_busy), 32'd1);
        chk({tag, ".cap_valid"}, 32'(o_byte_valid), 32'd0);
        tick();
        for (int b = 0; b < 4; b++) begin
            chk({tag, ".valid"}, 32'(o_byte_valid), 32'd1);
            chk({tag, ".byte"}, 32'(o_byte_data), 32'(e[31:24]));
            chk({tag, ".txv_early"}, 32'(o_tx_valid), 32'd0);
            e = e << 8;
            tick();
        end
        chk({tag, ".txv"}, 32'(o_tx_valid), 32'd1);
        chk({tag, ".fd"}, 32'(o_frame_done), 32'(exp_fd));
        chk({tag, ".done_valid"}, 32'(o_byte_valid), 32'd0);
        tick();
        chk({tag, ".txv_end"}, 32'(o_tx_valid), 32'd0);
        chk({tag, ".fd_end"}, 32'(o_frame_done), 32'd0);
        chk({tag, ".busy_end"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          x0;

        i_rst        = 1'b1;
        i_m0_r_en    = 1'b0;
        i_m1_r_en    = 1'b0;
        i_m0_rdata   = 32'h0;
        i_m1_rdata   = 32'h0;
        i_byte_ready = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;

        // Reset state
        chk("rst.valid", 32'(o_byte_valid), 32'd0);
        chk("rst.data", 32'(o_byte_data), 32'd0);
        chk("rst.txv", 32'(o_tx_valid), 32'd0);
        chk("rst.fd", 32'(o_frame_done), 32'd0);
        chk("rst.busy", 32'(o_busy), 32'd0);
        chk("rst.ovr", 32'(o_overrun), 32'd0);
        chk_cnt("rst.cnt", 32'd0);
        tick();

        // Bank0 sample, ready high
        run_sample("b0", 1'b1, 1'b0, 32'h1234_ABCD, 32'h5555_5555, 32'h1234_ABCD, 1'b0);
        chk_cnt("b0.cnt", 32'd1);

        // Bank1 sample with 3 cycles of backpressure on the second byte
        x0 = n_xfer;
        i_m1_r_en = 1'b1;
        tick();
        i_m1_r_en  = 1'b0;
        i_m0_rdata = 32'h0BAD_0BAD;
        i_m1_rdata = 32'hDEAD_BEEF;
        tick();
        chk("bp.b0", 32'(o_byte_data), 32'h0000_00DE);
        tick();
        i_byte_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp.hold_valid", 32'(o_byte_valid), 32'd1);
            chk("bp.hold_byte", 32'(o_byte_data), 32'h0000_00AD);
            tick();
        end
        i_byte_ready = 1'b1;
        chk("bp.b1", 32'(o_byte_data), 32'h0000_00AD);
        tick();
        chk("bp.b2", 32'(o_byte_data), 32'h0000_00BE);
        tick();
        chk("bp.b3", 32'(o_byte_data), 32'h0000_00EF);
        tick();
        chk("bp.txv", 32'(o_tx_valid), 32'd1);
        tick();
        chk("bp.xfers", 32'(n_xfer - x0), 32'd4);
        chk("bp.ovr", 32'(o_overrun), 32'd0);
        chk_cnt("bp.cnt", 32'd2);

        // Overrun: enable during SEND is flagged and ignored
        x0 = n_xfer;
        i_m0_r_en = 1'b1;
        tick();
        i_m0_r_en  = 1'b0;
        i_m0_rdata = 32'h0F1E_2D3C;
        tick();
        chk("ov.b0", 32'(o_byte_data), 32'h0000_000F);
        tick();
        chk("ov.b1", 32'(o_byte_data), 32'h0000_001E);
        i_m0_r_en  = 1'b1;
        i_m0_rdata = 32'hFFFF_FFFF;
        tick();
        i_m0_r_en = 1'b0;
        chk("ov.flag", 32'(o_overrun), 32'd1);
        chk("ov.b2", 32'(o_byte_data), 32'h0000_002D);
        tick();
        chk("ov.b3", 32'(o_byte_data), 32'h0000_003C);
        tick();
        chk("ov.txv", 32'(o_tx_valid), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("ov.no_txv", 32'(o_tx_valid), 32'd0);
            chk("ov.idle", 32'(o_busy), 32'd0);
            chk("ov.sticky", 32'(o_overrun), 32'd1);
            tick();
        end
        chk("ov.xfers", 32'(n_xfer - x0), 32'd4);
        chk_cnt("ov.cnt", 32'd3);

        // Simultaneous enables: bank0 wins
        run_sample("both", 1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        chk_cnt("both.cnt", 32'd4);

        // Reset in the middle of SEND after two bytes
        i_m0_r_en = 1'b1;
        tick();
        i_m0_r_en  = 1'b0;
        i_m0_rdata = 32'hAABB_CCDD;
        tick();
        chk("mr.b0", 32'(o_byte_data), 32'h0000_00AA);
        tick();
        chk("mr.b1", 32'(o_byte_data), 32'h0000_00BB);
        tick();
        chk("mr.b2", 32'(o_byte_data), 32'h0000_00CC);
        chk("mr.ovr_before", 32'(o_overrun), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("mr.valid", 32'(o_byte_valid), 32'd0);
        chk("mr.busy", 32'(o_busy), 32'd0);
        chk("mr.ovr", 32'(o_overrun), 32'd0);
        chk("mr.txv", 32'(o_tx_valid), 32'd0);
        chk_cnt("mr.cnt", 32'd0);
        tick();
        tick();
        chk("mr.stay_idle", 32'(o_busy), 32'd0);
        run_sample("mr.new", 1'b1, 1'b0, 32'h1122_3344, 32'h0, 32'h1122_3344, 1'b0);
        chk_cnt("mr.new_cnt", 32'd1);

        // Full frame of N samples from a clean counter, alternating banks
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        x0 = n_xfer;
        for (int i = 0; i < 32; i++) begin
            d = {8'(i), 8'(160 + i), 8'(255 - i), 8'(i ^ 90)};
            if (i % 2 == 0)
                run_sample("frame", 1'b1, 1'b0, d, ~d, d, (i == 31));
            else
                run_sample("frame", 1'b0, 1'b1, ~d, d, d, (i == 31));
        end
        chk("frame.xfers", 32'(n_xfer - x0), 32'd128);
        chk_cnt("frame.cnt_wrap", 32'd0);
        run_sample("frame33", 1'b0, 1'b1, 32'h0, 32'hC0DE_F00D, 32'hC0DE_F00D, 1'b0);
        chk_cnt("frame33.cnt", 32'd1);
        chk("frame.ovr", 32'(o_overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
